// File: rtl/cnn_pkg.sv
// Shared types, default geometry and arithmetic helpers for the CNN post-convolution stages.
package cnn_pkg;

   localparam int DIM    = 8;
   localparam int KSIZE  = 3;
   localparam int DEF_W  = 8;
   localparam int DEF_OW = DIM - KSIZE + 1;
   localparam int DEF_OH = DIM - KSIZE + 1;

   // Helpers work on a wide signed type so any data width W fits after sign extension.
   localparam int CALC_W = 32;
   typedef logic signed [CALC_W-1:0] calc_t;

   typedef enum logic [1:0] {
      FILL,
      EMIT,
      DISCARD
   } pool_state_t;

   function automatic calc_t relu(input calc_t x);
      return x[CALC_W-1] ? '0 : x;
   endfunction

   function automatic calc_t max2(input calc_t a, input calc_t b);
      return (a > b) ? a : b;
   endfunction

   function automatic int idx_bits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer holding one horizontal-pair maximum per pooling window of the previous row.
module pool_line_buf
   import cnn_pkg::*;
#(
   parameter int W     = DEF_W,
   parameter int DEPTH = DEF_OW / 2,
   parameter int IW    = idx_bits(DEPTH)
) (
   input  logic          clk,
   input  logic          i_wr_en,
   input  logic [IW-1:0] i_wr_idx,
   input  logic [W-1:0]  i_wr_data,
   input  logic [IW-1:0] i_rd_idx,
   output logic [W-1:0]  o_rd_data
);

   logic [W-1:0] r_mem [DEPTH];

   // NOTE: storage has no reset; every entry is rewritten in the even row before the odd row reads it.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_idx] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/relu_maxpool2.sv
// ReLU followed by 2x2 stride-2 max pooling over a raster-ordered convolution stream.
module relu_maxpool2
   import cnn_pkg::*;
#(
   parameter int W  = DEF_W,
   parameter int OW = DEF_OW,
   parameter int OH = DEF_OH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                in_valid,
   input  logic signed [W-1:0] in_data,
   output logic                out_valid,
   output logic signed [W-1:0] out_data,
   output logic                frame_done
);

   localparam int CW = idx_bits(OW);
   localparam int RW = idx_bits(OH);
   localparam int NB = OW / 2;
   localparam int IW = idx_bits(NB);

   localparam logic [CW-1:0] COL_LAST     = CW'(OW - 1);
   localparam logic [CW-1:0] COL_WIN_LAST = CW'(2 * (OW / 2) - 1);
   localparam logic [RW-1:0] ROW_LAST     = RW'(OH - 1);
   localparam logic [RW-1:0] ROW_PRE_LAST = RW'(OH - 2);
   localparam logic [RW-1:0] ROW_WIN_LAST = RW'(2 * (OH / 2) - 1);
   localparam bit            OH_ODD       = (OH % 2) == 1;

   pool_state_t         r_state;
   logic [CW-1:0]       r_col;
   logic [RW-1:0]       r_row;
   logic signed [W-1:0] r_hreg;
   logic                r_out_valid;
   logic signed [W-1:0] r_out_data;
   logic                r_frame_done;

   pool_state_t         w_state;
   pool_state_t         w_state_nxt;
   logic [CW-1:0]       w_col;
   logic [CW-1:0]       w_col_nxt;
   logic [RW-1:0]       w_row;
   logic [RW-1:0]       w_row_nxt;
   logic signed [W-1:0] w_relu;
   logic signed [W-1:0] w_hmax;
   logic signed [W-1:0] w_lbuf_rd;
   logic signed [W-1:0] w_pool;
   logic [IW-1:0]       w_idx;
   logic                w_pair_end;
   logic                w_emit;
   logic                w_lbuf_wr;

   // A start overrides the stored position so a same-cycle sample is pixel (0,0).
   assign w_col   = start ? '0 : r_col;
   assign w_row   = start ? '0 : r_row;
   assign w_state = start ? FILL : r_state;

   assign w_relu     = W'(relu(calc_t'(in_data)));
   assign w_hmax     = W'(max2(calc_t'(r_hreg), calc_t'(w_relu)));
   assign w_pool     = W'(max2(calc_t'(w_lbuf_rd), calc_t'(w_hmax)));
   assign w_idx      = IW'(w_col >> 1);
   assign w_pair_end = in_valid && w_col[0];
   assign w_emit     = w_pair_end && (w_state == EMIT);
   assign w_lbuf_wr  = w_pair_end && (w_state == FILL);

   pool_line_buf #(
      .W     (W),
      .DEPTH (NB),
      .IW    (IW)
   ) u_lbuf (
      .clk       (clk),
      .i_wr_en   (w_lbuf_wr),
      .i_wr_idx  (w_idx),
      .i_wr_data (w_hmax),
      .i_rd_idx  (w_idx),
      .o_rd_data (w_lbuf_rd)
   );

   always_comb begin
      // NOTE: every output gets a default first, so no path leaves a latch behind.
      w_col_nxt   = w_col;
      w_row_nxt   = w_row;
      w_state_nxt = w_state;
      if (in_valid) begin
         if (w_col == COL_LAST) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
            case (w_state)
               FILL:    w_state_nxt = EMIT;
               EMIT:    w_state_nxt = (OH_ODD && (w_row == ROW_PRE_LAST)) ? DISCARD : FILL;
               DISCARD: w_state_nxt = FILL;
               default: w_state_nxt = FILL;
            endcase
         end else begin
            w_col_nxt = w_col + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= FILL;
         r_col        <= '0;
         r_row        <= '0;
         r_hreg       <= '0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_frame_done <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         r_state      <= w_state_nxt;
         r_col        <= w_col_nxt;
         r_row        <= w_row_nxt;
         r_out_valid  <= w_emit;
         r_frame_done <= w_emit && (w_row == ROW_WIN_LAST) && (w_col == COL_WIN_LAST);
         if (in_valid && !w_col[0] && (w_col != COL_LAST)) begin
            r_hreg <= w_relu;
         end
         if (w_emit) begin
            r_out_data <= w_pool;
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_relu_maxpool2.sv
// Scoreboard bench for relu_maxpool2: a 6x6 and a 5x5 instance checked against a frame-image model.
module tb_relu_maxpool2;

   typedef struct {
      int data;
      bit fd;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic              start6 = 1'b0, in_valid6 = 1'b0;
   logic signed [7:0] in_data6 = '0;
   logic              out_valid6, frame_done6;
   logic signed [7:0] out_data6;

   logic              start5 = 1'b0, in_valid5 = 1'b0;
   logic signed [7:0] in_data5 = '0;
   logic              out_valid5, frame_done5;
   logic signed [7:0] out_data5;

   exp_t q6[$];
   exp_t q5[$];
   int   log6[$];
   int   log5[$];
   int   fd_idx6 = -1;
   int   fd_idx5 = -1;
   int   img[2][6][6];
   int   pos[2];
   int   cyc_cnt = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   ramp6_exp[9] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
   int   ramp5_exp[4] = '{6, 8, 16, 18};

   relu_maxpool2 #(.W(8), .OW(6), .OH(6)) u_dut6 (
      .clk        (clk),
      .rst        (rst),
      .start      (start6),
      .in_valid   (in_valid6),
      .in_data    (in_data6),
      .out_valid  (out_valid6),
      .out_data   (out_data6),
      .frame_done (frame_done6)
   );

   relu_maxpool2 #(.W(8), .OW(5), .OH(5)) u_dut5 (
      .clk        (clk),
      .rst        (rst),
      .start      (start5),
      .in_valid   (in_valid5),
      .in_data    (in_data5),
      .out_valid  (out_valid5),
      .out_data   (out_data5),
      .frame_done (frame_done5)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: keep the whole frame as an image; a window's result is the max of its four
   // rectified pixels, due once its bottom-right pixel has been seen.
   function automatic void model(input int k, input logic signed [7:0] d, input int cyc);
      int   ow, oh, r, c, m;
      exp_t e;
      ow = (k == 0) ? 6 : 5;
      oh = ow;
      r  = pos[k] / ow;
      c  = pos[k] % ow;
      img[k][r][c] = (d < 0) ? 0 : int'(d);
      if ((r % 2 == 1) && (c % 2 == 1) && (r < 2 * (oh / 2)) && (c < 2 * (ow / 2))) begin
         m = 0;
         for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
               if (img[k][r-dr][c-dc] > m) m = img[k][r-dr][c-dc];
         e.data = m;
         e.fd   = (r == 2 * (oh / 2) - 1) && (c == 2 * (ow / 2) - 1);
         e.cyc  = cyc;
         if (k == 0) q6.push_back(e);
         else        q5.push_back(e);
      end
      pos[k] = (pos[k] + 1) % (ow * oh);
   endfunction

   // Monitor: sample just after each rising edge and reconcile against the expectation queues.
   initial forever begin
      exp_t e;
      @(posedge clk);
      cyc_cnt++;
      #1;
      if (out_valid6) begin
         if (q6.size() == 0) check("dut6 unexpected out_valid", 1, 0);
         else begin
            e = q6.pop_front();
            check("dut6 out_data", int'(out_data6), e.data);
            check("dut6 frame_done", int'(frame_done6), int'(e.fd));
            check("dut6 latency cycle", cyc_cnt, e.cyc);
         end
         log6.push_back(int'(out_data6));
         if (frame_done6) fd_idx6 = log6.size() - 1;
      end else if (frame_done6) check("dut6 frame_done without out_valid", 1, 0);
      if (out_valid5) begin
         if (q5.size() == 0) check("dut5 unexpected out_valid", 1, 0);
         else begin
            e = q5.pop_front();
            check("dut5 out_data", int'(out_data5), e.data);
            check("dut5 frame_done", int'(frame_done5), int'(e.fd));
            check("dut5 latency cycle", cyc_cnt, e.cyc);
         end
         log5.push_back(int'(out_data5));
         if (frame_done5) fd_idx5 = log5.size() - 1;
      end else if (frame_done5) check("dut5 frame_done without out_valid", 1, 0);
   end

   task automatic step(input bit v6, input bit s6, input logic [7:0] d6,
                       input bit v5, input bit s5, input logic [7:0] d5);
      @(negedge clk);
      start6 = s6; in_valid6 = v6; in_data6 = d6;
      start5 = s5; in_valid5 = v5; in_data5 = d5;
      if (s6) pos[0] = 0;
      if (v6) model(0, d6, cyc_cnt + 1);
      if (s5) pos[1] = 0;
      if (v5) model(1, d5, cyc_cnt + 1);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic drain(input string name);
      idle(4);
      check({name, " dut6 pending outputs"}, q6.size(), 0);
      check({name, " dut5 pending outputs"}, q5.size(), 0);
   endtask

   task automatic clear_logs;
      log6.delete(); log5.delete();
      fd_idx6 = -1; fd_idx5 = -1;
   endtask

   task automatic ramp6(input bit toggle);
      for (int i = 0; i < 36; i++) begin
         step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0, 8'h00);
         if (toggle) step(1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, 8'h00);
      end
   endtask

   task automatic check_ramp6(input string name);
      check({name, " output count"}, log6.size(), 9);
      for (int i = 0; i < 9; i++)
         if (i < log6.size()) check($sformatf("%s output %0d", name, i), log6[i], ramp6_exp[i]);
      check({name, " frame_done position"}, fd_idx6, 8);
   endtask

   task automatic check_ramp5(input string name, input int first);
      check({name, " output count"}, log5.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < log5.size())
            check($sformatf("%s output %0d", name, i), log5[i], (i == 0) ? first : ramp5_exp[i]);
      check({name, " frame_done position"}, fd_idx5, 3);
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1;
      start6 = 1'b0; in_valid6 = 1'b0; start5 = 1'b0; in_valid5 = 1'b0;
      q6.delete(); q5.delete();
      #1;
      check("reset out_valid", int'(out_valid6) + int'(out_valid5), 0);
      check("reset out_data", int'(out_data6) + int'(out_data5), 0);
      check("reset frame_done", int'(frame_done6) + int'(frame_done5), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      pos[0] = 0; pos[1] = 0;
   endtask

   initial begin
      pos[0] = 0; pos[1] = 0;
      do_reset();

      // Continuous ramp on the 6x6 map.
      clear_logs();
      ramp6(1'b0);
      drain("ramp6");
      check_ramp6("ramp6");

      // All-negative input rectifies to zero.
      clear_logs();
      repeat (36) step(1'b1, 1'b0, 8'hFB, 1'b0, 1'b0, 8'h00);
      drain("negative");
      check("negative output count", log6.size(), 9);
      foreach (log6[i]) check($sformatf("negative output %0d", i), log6[i], 0);
      check("negative frame_done position", fd_idx6, 8);

      // Odd 5x5 map: last column and last row ignored.
      clear_logs();
      for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'(i));
      drain("ramp5");
      check_ramp5("ramp5", 6);

      // Bubbles every other cycle.
      clear_logs();
      ramp6(1'b1);
      drain("bubbles");
      check_ramp6("bubbles");

      // Reset in mid-frame, then a clean ramp.
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0, 8'h00);
      do_reset();
      clear_logs();
      idle(3);
      ramp6(1'b0);
      drain("after reset");
      check_ramp6("after reset");

      // Start pulse after 15 samples restarts the frame.
      for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0, 8'h00);
      clear_logs();
      step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
      for (int i = 1; i < 36; i++) step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0, 8'h00);
      drain("start restart");
      check_ramp6("start restart");

      // Start coinciding with the bottom-right pixel of window (0,0): no output for it.
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'(i));
      clear_logs();
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'd100);
      for (int i = 1; i < 25; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'(i));
      drain("start on window end");
      check_ramp5("start on window end", 100);

      // Random data, valid gaps and occasional starts on both instances.
      for (int i = 0; i < 1600; i++) begin
         if (i == 800) do_reset();
         step($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0, 8'($urandom),
              $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0, 8'($urandom));
      end
      drain("random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
